// File: rtl/y86_pred_pkg.sv
// Shared types and helpers for the parametrised gshare predictor.
// Counter helpers carry up to 16-bit counters; callers slice to CTR_BITS.
package y86_pred_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pred_state_e;

  localparam int unsigned CTR_MAX_W = 16;

  function automatic logic [CTR_MAX_W-1:0] ctr_update(
    input logic [CTR_MAX_W-1:0] ctr,
    input logic                 taken,
    input int unsigned          width
  );
    logic [CTR_MAX_W-1:0] max_v;
    max_v = CTR_MAX_W'((32'd1 << width) - 32'd1);
    if (taken) begin
      return (ctr == max_v) ? ctr : ctr + 1'b1;
    end
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

  // Weakly-not-taken: all ones below the MSB.
  function automatic logic [CTR_MAX_W-1:0] ctr_wnt(input int unsigned width);
    return CTR_MAX_W'((32'd1 << (width - 1)) - 32'd1);
  endfunction

  function automatic logic [31:0] hash_idx(
    input logic [63:0] pc,
    input int unsigned lsb,
    input logic [31:0] hist
  );
    return 32'(pc >> lsb) ^ hist;
  endfunction

endpackage

// File: rtl/pred_pht_ram.sv
// Pattern history table: two asynchronous read ports (predict, train
// read-modify-write) and one synchronous write port.
module pred_pht_ram #(
  parameter int IDX_W  = 7,
  parameter int DATA_W = 2
) (
  input  logic              clk_i,
  input  logic [IDX_W-1:0]  rd_p_addr_i,
  output logic [DATA_W-1:0] rd_p_data_o,
  input  logic [IDX_W-1:0]  rd_t_addr_i,
  output logic [DATA_W-1:0] rd_t_data_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] mem_q [2**IDX_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_p_data_o = mem_q[rd_p_addr_i];
  assign rd_t_data_o = mem_q[rd_t_addr_i];

endmodule

// File: rtl/pred_gshare_param.sv
// Parametrised gshare direction predictor with speculative history and
// sequenced PHT init. Define PRED_PERF_CNT_EN to build the perf counters.
//
//   state | meaning
//   INIT  | sweeping PHT to weakly-not-taken, outputs quiet
//   RUN   | predicting and training
module pred_gshare_param
  import y86_pred_pkg::*;
#(
  parameter int INDEX_BITS = 7,
  parameter int HIST_BITS  = 7,
  parameter int CTR_BITS   = 2,
  parameter int PC_LSB     = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 pred_valid_i,
  input  logic [63:0]          pred_pc_i,
  output logic                 pred_taken_o,
  output logic [HIST_BITS-1:0] pred_hist_o,
  input  logic                 train_valid_i,
  input  logic [63:0]          train_pc_i,
  input  logic [HIST_BITS-1:0] train_hist_i,
  input  logic                 train_taken_i,
  input  logic                 train_mispred_i,
  output logic                 ready_o,
  output logic [31:0]          perf_pred_cnt_o,
  output logic [31:0]          perf_mispred_cnt_o
);

  pred_state_e           state_q, state_d;
  logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
  logic [HIST_BITS-1:0]  spec_hist_q, spec_hist_d;

  logic [31:0]           hash_p, hash_t;
  logic [INDEX_BITS-1:0] idx_p, idx_t;
  logic [CTR_BITS-1:0]   ctr_p, ctr_t;
  logic [CTR_MAX_W-1:0]  upd_full, wnt_full;
  logic [HIST_BITS:0]    hist_repair, hist_shift;

  logic                  pht_we;
  logic [INDEX_BITS-1:0] pht_waddr;
  logic [CTR_BITS-1:0]   pht_wdata;
  logic                  pred_taken;
  logic                  run;
  logic                  unused_bits;

  assign hash_p = hash_idx(pred_pc_i, PC_LSB, 32'(spec_hist_q));
  assign hash_t = hash_idx(train_pc_i, PC_LSB, 32'(train_hist_i));
  assign idx_p  = hash_p[INDEX_BITS-1:0];
  assign idx_t  = hash_t[INDEX_BITS-1:0];

  assign upd_full = ctr_update(CTR_MAX_W'(ctr_t), train_taken_i, CTR_BITS);
  assign wnt_full = ctr_wnt(CTR_BITS);

  // Low HIST_BITS of the concatenation also covers HIST_BITS == 1.
  assign hist_repair = {train_hist_i, train_taken_i};
  assign hist_shift  = {spec_hist_q, pred_taken};

  assign run = (state_q == RUN);

  pred_pht_ram #(
    .IDX_W  (INDEX_BITS),
    .DATA_W (CTR_BITS)
  ) u_pht (
    .clk_i       (clk_i),
    .rd_p_addr_i (idx_p),
    .rd_p_data_o (ctr_p),
    .rd_t_addr_i (idx_t),
    .rd_t_data_o (ctr_t),
    .we_i        (pht_we),
    .wr_addr_i   (pht_waddr),
    .wr_data_i   (pht_wdata)
  );

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    spec_hist_d = spec_hist_q;
    pht_we      = 1'b0;
    pht_waddr   = init_idx_q;
    pht_wdata   = wnt_full[CTR_BITS-1:0];
    pred_taken  = 1'b0;
    case (state_q)
      INIT: begin
        pht_we     = 1'b1;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        pred_taken = ctr_p[CTR_BITS-1];
        if (train_valid_i) begin
          pht_we    = 1'b1;
          pht_waddr = idx_t;
          pht_wdata = upd_full[CTR_BITS-1:0];
        end
        if (train_valid_i && train_mispred_i) begin
          spec_hist_d = hist_repair[HIST_BITS-1:0];
        end else if (pred_valid_i) begin
          spec_hist_d = hist_shift[HIST_BITS-1:0];
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= INIT;
      init_idx_q  <= '0;
      spec_hist_q <= '0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      spec_hist_q <= spec_hist_d;
    end
  end

  assign pred_taken_o = pred_taken;
  assign pred_hist_o  = spec_hist_q;
  assign ready_o      = run;

`ifdef PRED_PERF_CNT_EN
  logic [31:0] perf_pred_q, perf_pred_d;
  logic [31:0] perf_mis_q, perf_mis_d;

  always_comb begin
    perf_pred_d = perf_pred_q;
    perf_mis_d  = perf_mis_q;
    if (pred_valid_i && run) begin
      perf_pred_d = perf_pred_q + 32'd1;
    end
    if (train_valid_i && train_mispred_i && run) begin
      perf_mis_d = perf_mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_pred_q <= '0;
      perf_mis_q  <= '0;
    end else begin
      perf_pred_q <= perf_pred_d;
      perf_mis_q  <= perf_mis_d;
    end
  end

  assign perf_pred_cnt_o    = perf_pred_q;
  assign perf_mispred_cnt_o = perf_mis_q;
`else
  assign perf_pred_cnt_o    = 32'd0;
  assign perf_mispred_cnt_o = 32'd0;
`endif

  assign unused_bits = ^{hash_p, hash_t, upd_full, wnt_full};

endmodule

// File: tb/tb_pred_gshare_param.sv
// Directed bench for pred_gshare_param (default parameters) with an
// abstract predictor model checked every cycle.
module tb_pred_gshare_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pred_valid;
  logic [63:0] pred_pc;
  logic        pred_taken_o;
  logic [6:0]  pred_hist_o;
  logic        train_valid;
  logic [63:0] train_pc;
  logic [6:0]  train_hist;
  logic        train_taken;
  logic        train_mispred;
  logic        ready_o;
  logic [31:0] perf_pred_cnt_o;
  logic [31:0] perf_mispred_cnt_o;

  int total = 0;
  int bad   = 0;

  // Model state: counters as plain integers 0..3, history as an integer.
  int pht [128];
  int m_hist;
  int m_cnt;
  bit m_ready;
  int m_pc_cnt;
  int m_mis_cnt;

  always #5 clk = ~clk;

  pred_gshare_param dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .pred_valid_i       (pred_valid),
    .pred_pc_i          (pred_pc),
    .pred_taken_o       (pred_taken_o),
    .pred_hist_o        (pred_hist_o),
    .train_valid_i      (train_valid),
    .train_pc_i         (train_pc),
    .train_hist_i       (train_hist),
    .train_taken_i      (train_taken),
    .train_mispred_i    (train_mispred),
    .ready_o            (ready_o),
    .perf_pred_cnt_o    (perf_pred_cnt_o),
    .perf_mispred_cnt_o (perf_mispred_cnt_o)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int p_index();
    return (int'(pred_pc % 128)) ^ m_hist;
  endfunction

  function automatic bit m_pred();
    return m_ready && (pht[p_index()] >= 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready   = 1'b0;
      m_cnt     = 0;
      m_hist    = 0;
      m_pc_cnt  = 0;
      m_mis_cnt = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 128) begin
        m_ready = 1'b1;
        for (int i = 0; i < 128; i++) pht[i] = 1;
      end
    end else begin
      bit pt;
      int it;
      pt = m_pred();
      if (pred_valid) m_pc_cnt++;
      if (train_valid && train_mispred) m_mis_cnt++;
      if (train_valid) begin
        it = (int'(train_pc % 128)) ^ int'(train_hist);
        if (train_taken) pht[it] = (pht[it] == 3) ? 3 : pht[it] + 1;
        else             pht[it] = (pht[it] == 0) ? 0 : pht[it] - 1;
      end
      if (train_valid && train_mispred)
        m_hist = ((int'(train_hist) * 2) + int'(train_taken)) % 128;
      else if (pred_valid)
        m_hist = ((m_hist * 2) + int'(pt)) % 128;
    end
  end

  always @(negedge clk) begin
    check("pred_taken", 64'(pred_taken_o), 64'(m_pred()));
    check("pred_hist", 64'(pred_hist_o), 64'(m_hist));
    check("ready", 64'(ready_o), 64'(m_ready));
`ifdef PRED_PERF_CNT_EN
    check("perf_pred", 64'(perf_pred_cnt_o), 64'(m_pc_cnt));
    check("perf_mis", 64'(perf_mispred_cnt_o), 64'(m_mis_cnt));
`else
    check("perf_pred", 64'(perf_pred_cnt_o), 64'd0);
    check("perf_mis", 64'(perf_mispred_cnt_o), 64'd0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pred_valid    = 1'b0;
    pred_pc       = '0;
    train_valid   = 1'b0;
    train_pc      = '0;
    train_hist    = '0;
    train_taken   = 1'b0;
    train_mispred = 1'b0;
  endtask

  task automatic train(input logic [63:0] pc, input logic [6:0] h, input logic t, input logic m);
    train_valid   = 1'b1;
    train_pc      = pc;
    train_hist    = h;
    train_taken   = t;
    train_mispred = m;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_o && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    clr();
    repeat (3) tick();
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_hist", 64'(pred_hist_o), 64'd0);
    rst_n = 1'b1;
    wait_ready(n);
    check("init_len", 64'(n), 64'd128);

    pred_pc = 64'h0;   #1 check("init_pc0", 64'(pred_taken_o), 64'd0);
    pred_pc = 64'h40;  #1 check("init_pc40", 64'(pred_taken_o), 64'd0);
    pred_pc = 64'h1FF; #1 check("init_pc1ff", 64'(pred_taken_o), 64'd0);
    tick();

    // Two taken trains at 0x40 move 01 -> 11.
    train(64'h40, 7'd0, 1'b1, 1'b0);
    tick(); tick();
    clr();
    pred_pc = 64'h40;
    #1 check("trained_40", 64'(pred_taken_o), 64'd1);
    tick();

    // Saturation at index 0x10.
    train(64'h10, 7'd0, 1'b1, 1'b0);
    repeat (4) tick();
    train(64'h10, 7'd0, 1'b0, 1'b0);
    tick();
    clr(); pred_pc = 64'h10;
    #1 check("sat_after_1nt", 64'(pred_taken_o), 64'd1);
    train(64'h10, 7'd0, 1'b0, 1'b0);
    repeat (3) tick();
    clr(); pred_pc = 64'h10;
    #1 check("sat_floor", 64'(pred_taken_o), 64'd0);
    train(64'h10, 7'd0, 1'b1, 1'b0);
    tick();
    clr(); pred_pc = 64'h10;
    #1 check("no_underflow", 64'(pred_taken_o), 64'd0);
    tick();

    // Repair priority over a same-cycle prediction.
    train(64'h200, 7'b0000010, 1'b1, 1'b1);
    tick();
    clr();
    check("repair_setup", 64'(pred_hist_o), 64'b0000101);
    pred_valid = 1'b1;
    pred_pc    = 64'h33;
    train(64'h200, 7'b0000011, 1'b0, 1'b1);
    tick();
    clr();
    check("repair_wins", 64'(pred_hist_o), 64'b0000110);
    train(64'h200, 7'd0, 1'b0, 1'b1);
    tick();
    clr();

    // Same-index train and predict: old counter visible this cycle.
    pred_pc = 64'h20;
    train(64'h20, 7'd0, 1'b1, 1'b0);
    #1 check("same_idx_old", 64'(pred_taken_o), 64'd0);
    tick();
    train_valid = 1'b0;
    #1 check("same_idx_new", 64'(pred_taken_o), 64'd1);

    // Speculative shift: idx 32 (10) then idx 33 (01) -> history 10.
    pred_valid = 1'b1;
    tick(); tick();
    clr();
    check("spec_shift", 64'(pred_hist_o), 64'b0000010);
    tick();

    // Reset in the middle of INIT restarts the full sweep.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (50) tick();
    rst_n = 1'b0;
    #1 check("mid_init_ready", 64'(ready_o), 64'd0);
    tick();
    rst_n = 1'b1;
    wait_ready(n);
    check("reinit_len", 64'(n), 64'd128);

    // 10 predictions, 3 of the cycles also mispredict.
    for (int i = 0; i < 10; i++) begin
      clr();
      pred_valid = 1'b1;
      pred_pc    = 64'(i * 5);
      if (i < 3) train(64'(i * 9), 7'(i), 1'(i % 2), 1'b1);
      tick();
    end
    clr();
`ifdef PRED_PERF_CNT_EN
    check("perf_pred_10", 64'(perf_pred_cnt_o), 64'd10);
    check("perf_mis_3", 64'(perf_mispred_cnt_o), 64'd3);
`else
    check("perf_pred_off", 64'(perf_pred_cnt_o), 64'd0);
    check("perf_mis_off", 64'(perf_mispred_cnt_o), 64'd0);
`endif

    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      pred_valid    = 1'($urandom_range(0, 1));
      pred_pc       = 64'($urandom_range(0, 511));
      train_valid   = 1'($urandom_range(0, 1));
      train_pc      = 64'($urandom_range(0, 511));
      train_hist    = 7'($urandom_range(0, 127));
      train_taken   = 1'($urandom_range(0, 1));
      train_mispred = ($urandom_range(0, 3) == 0);
      tick();
    end
    clr();
    tick();

    rst_n = 1'b0;
    #1;
    check("perf_pred_rst", 64'(perf_pred_cnt_o), 64'd0);
    check("perf_mis_rst", 64'(perf_mispred_cnt_o), 64'd0);
    check("ready_rst", 64'(ready_o), 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
